// File: rtl/mm_regfile_if.sv
// mm_regfile_if: read ports, issue/scoreboard handshake, writeback and sb_err between decode/ALU (master) and mm_regfile (slave)
interface mm_regfile_if #(parameter int W = 64);
  logic [2:0]   rd_a_idx;
  logic [2:0]   rd_b_idx;
  logic [W-1:0] rd_a_data;
  logic [W-1:0] rd_b_data;
  logic         iss_valid;
  logic         iss_use_a;
  logic         iss_use_b;
  logic         iss_wr;
  logic [2:0]   iss_dest;
  logic         iss_ready;
  logic         wb_valid;
  logic [2:0]   wb_dest;
  logic [W-1:0] wb_data;
  logic         wb_d32;
  logic         sb_err;
  modport master (
    output rd_a_idx, rd_b_idx, iss_valid, iss_use_a, iss_use_b, iss_wr, iss_dest,
           wb_valid, wb_dest, wb_data, wb_d32,
    input  rd_a_data, rd_b_data, iss_ready, sb_err
  );
  modport slave (
    input  rd_a_idx, rd_b_idx, iss_valid, iss_use_a, iss_use_b, iss_wr, iss_dest,
           wb_valid, wb_dest, wb_data, wb_d32,
    output rd_a_data, rd_b_data, iss_ready, sb_err
  );
endinterface

// File: rtl/mm_regfile.sv
// mm_regfile: 8x64 MMX register file with scoreboard and writeback bypass; ports clk, rst (sync, active-high), bus (mm_regfile_if.slave: reads, issue, writeback, sb_err)
module mm_regfile #(
  parameter int NREG = 8,
  parameter int W    = 64
) (
  input logic        clk,
  input logic        rst,
  mm_regfile_if.slave bus
);
  logic [W-1:0]    r_regs [NREG];
  logic [NREG-1:0] r_pend;
  logic            r_sb_err;
  logic [W-1:0]    w_wd;
  logic [NREG-1:0] w_ep;
  logic            w_ready;
  always_comb begin
    w_wd = bus.wb_d32 ? {{(W-32){1'b0}}, bus.wb_data[31:0]} : bus.wb_data;
    w_ep = r_pend;
    if (bus.wb_valid) w_ep[bus.wb_dest] = 1'b0;
    w_ready = ~(bus.iss_use_a & w_ep[bus.rd_a_idx]) &
              ~(bus.iss_use_b & w_ep[bus.rd_b_idx]) &
              ~(bus.iss_wr & w_ep[bus.iss_dest]);
  end
  assign bus.rd_a_data = (bus.wb_valid && bus.wb_dest == bus.rd_a_idx) ? w_wd : r_regs[bus.rd_a_idx];
  assign bus.rd_b_data = (bus.wb_valid && bus.wb_dest == bus.rd_b_idx) ? w_wd : r_regs[bus.rd_b_idx];
  assign bus.iss_ready = w_ready;
  assign bus.sb_err    = r_sb_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_pend   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      if (bus.wb_valid) begin
        r_regs[bus.wb_dest] <= w_wd;
        r_pend[bus.wb_dest] <= 1'b0;
        if (!r_pend[bus.wb_dest]) r_sb_err <= 1'b1;
      end
      // issue set comes last so it wins over a same-register writeback clear
      if (bus.iss_valid && w_ready && bus.iss_wr) r_pend[bus.iss_dest] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mm_regfile.sv
// tb_mm_regfile: directed self-checking bench for mm_regfile
module tb_mm_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  mm_regfile_if #(.W(64)) bus ();
  mm_regfile #(.NREG(8), .W(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.iss_valid = 0; bus.iss_use_a = 0; bus.iss_use_b = 0; bus.iss_wr = 0; bus.iss_dest = 0;
    bus.wb_valid = 0; bus.wb_dest = 0; bus.wb_data = 0; bus.wb_d32 = 0;
  endtask
  task automatic issue(input logic [2:0] d);
    bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dest = d; bus.iss_use_a = 0; bus.iss_use_b = 0;
  endtask
  initial begin
    idle();
    bus.rd_a_idx = 0; bus.rd_b_idx = 0;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_a_idx = 3'(i); bus.rd_b_idx = 3'(7 - i);
      bus.iss_use_a = 1; bus.iss_use_b = 1; bus.iss_wr = 1; bus.iss_dest = 3'(i);
      #1;
      chk("rst_rd_a", bus.rd_a_data, 64'h0);
      chk("rst_rd_b", bus.rd_b_data, 64'h0);
      chk("rst_ready", 64'(bus.iss_ready), 64'h1);
    end
    chk("rst_sb_err", 64'(bus.sb_err), 64'h0);
    idle();
    // PADDW -> MM3, dependent consumer stalls until writeback
    issue(3);
    tick();
    idle();
    bus.iss_valid = 1; bus.iss_use_a = 1; bus.rd_a_idx = 3;
    #1 chk("raw_stall", 64'(bus.iss_ready), 64'h0);
    tick();
    chk("raw_stall2", 64'(bus.iss_ready), 64'h0);
    bus.wb_valid = 1; bus.wb_dest = 3; bus.wb_data = 64'h0001_0002_0003_0004;
    #1;
    chk("raw_release", 64'(bus.iss_ready), 64'h1);
    chk("bypass_a", bus.rd_a_data, 64'h0001_0002_0003_0004);
    tick();
    idle();
    bus.rd_a_idx = 3; bus.rd_b_idx = 3;
    #1;
    chk("reg3_a", bus.rd_a_data, 64'h0001_0002_0003_0004);
    chk("reg3_b_same", bus.rd_b_data, 64'h0001_0002_0003_0004);
    bus.iss_use_a = 1; bus.iss_wr = 1; bus.iss_dest = 3;
    #1 chk("pend3_clear", 64'(bus.iss_ready), 64'h1);
    idle();
    // MOVD-style write to MM5
    issue(5);
    tick();
    idle();
    bus.wb_valid = 1; bus.wb_d32 = 1; bus.wb_dest = 5; bus.wb_data = 64'hDEAD_BEEF_1234_5678; bus.rd_b_idx = 5;
    #1 chk("movd_bypass", bus.rd_b_data, 64'h0000_0000_1234_5678);
    tick();
    idle();
    #1;
    chk("movd_reg", bus.rd_b_data, 64'h0000_0000_1234_5678);
    chk("movd_no_err", 64'(bus.sb_err), 64'h0);
    // WAW: issue MM2, then wb MM2 and re-issue MM2 in the same cycle, plus issue/wb on distinct regs
    issue(2);
    tick();
    bus.iss_dest = 2; bus.wb_valid = 1; bus.wb_dest = 2; bus.wb_data = 64'hAAAA_BBBB_CCCC_DDDD;
    #1 chk("waw_ready", 64'(bus.iss_ready), 64'h1);
    tick();
    idle();
    bus.iss_valid = 1; bus.iss_use_b = 1; bus.rd_b_idx = 2;
    #1 chk("set_wins_stall", 64'(bus.iss_ready), 64'h0);
    chk("mm2_data", bus.rd_b_data, 64'hAAAA_BBBB_CCCC_DDDD);
    idle();
    issue(0);
    bus.wb_valid = 1; bus.wb_dest = 2; bus.wb_data = 64'h1;
    tick();
    idle();
    bus.iss_use_a = 1; bus.rd_a_idx = 0;
    #1 chk("diff_set", 64'(bus.iss_ready), 64'h0);
    bus.rd_a_idx = 2;
    #1 chk("diff_clear", 64'(bus.iss_ready), 64'h1);
    chk("diff_wdata", bus.rd_a_data, 64'h1);
    idle();
    // unexpected writeback to MM6 sets sticky sb_err
    bus.wb_valid = 1; bus.wb_dest = 6; bus.wb_data = 64'h6666_0000_0000_0006;
    #1 chk("err_pre", 64'(bus.sb_err), 64'h0);
    tick();
    idle();
    bus.rd_a_idx = 6;
    #1;
    chk("err_set", 64'(bus.sb_err), 64'h1);
    chk("err_write", bus.rd_a_data, 64'h6666_0000_0000_0006);
    tick(); tick();
    chk("err_sticky", 64'(bus.sb_err), 64'h1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("err_rst", 64'(bus.sb_err), 64'h0);
    chk("reg6_rst", bus.rd_a_data, 64'h0);
    // reset overrides pending state and a same-cycle writeback
    issue(1);
    tick();
    issue(4);
    tick();
    idle();
    bus.iss_wr = 1; bus.iss_dest = 1;
    #1 chk("pend1", 64'(bus.iss_ready), 64'h0);
    bus.iss_dest = 4;
    #1 chk("pend4", 64'(bus.iss_ready), 64'h0);
    idle();
    rst = 1;
    bus.wb_valid = 1; bus.wb_dest = 1; bus.wb_data = 64'h5555_5555_5555_5555;
    tick();
    rst = 0;
    idle();
    bus.rd_a_idx = 1;
    bus.iss_use_a = 1; bus.iss_use_b = 1; bus.rd_b_idx = 4; bus.iss_wr = 1; bus.iss_dest = 4;
    #1;
    chk("rst_reg1", bus.rd_a_data, 64'h0);
    chk("rst_ready_all", 64'(bus.iss_ready), 64'h1);
    chk("rst_err_clear", 64'(bus.sb_err), 64'h0);
    idle();
    bus.wb_valid = 1; bus.wb_dest = 4; bus.wb_data = 64'h4;
    tick();
    idle();
    #1 chk("late_wb_err", 64'(bus.sb_err), 64'h1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
